mem_access_stage: RTL and testbench

//   MEM pipeline stage: consumes EX/MEM register outputs, performs the data-memory access

---
 rtl/mem_stage_pkg.sv | 6 +
 rtl/mem_wait_timer.sv | 18 +
 rtl/mem_access_stage.sv | 96 +++++++++
 tb/tb_mem_access_stage.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths and FSM state encoding for the MEM pipeline stage
package mem_stage_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: wait-cycle counter with clear/enable and terminal flag at MAX_WAIT-1
module mem_wait_timer #(
  parameter int MAX_WAIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);
  localparam int CW = $clog2(MAX_WAIT);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + CW'(1);
  assign done = cnt == CW'(MAX_WAIT - 1);
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage driving a variable-latency req/ack data bus with stall, hold buffer and watchdog
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W = DEF_REG_W,
  parameter int MAX_WAIT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_stall_n,
  input  logic              mem_MemRead,
  input  logic              mem_MemWrite,
  input  logic              mem_WriteReg,
  input  logic              mem_data_mux,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic [DATA_W-1:0] mem_ALU_res,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              out_WriteReg,
  output logic              out_data_mux,
  output logic [REG_W-1:0]  out_rd,
  output logic [DATA_W-1:0] out_ALU_res,
  output logic [DATA_W-1:0] out_data_mem,
  output logic              stall_n,
  output logic              mem_err
);
  state_t state, next;
  logic access, is_load, req, stall, complete, timeout, tmr_done, hold_to;
  logic [DATA_W-1:0] hold_reg, done_data;
  assign access = mem_MemRead | mem_MemWrite;
  assign is_load = mem_MemRead & ~mem_MemWrite;
  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(state != WAIT || complete),
    .en(state == WAIT && !complete),
    .done(tmr_done)
  );
  always_comb begin
    next = state;
    req = 1'b0;
    stall = 1'b1;
    complete = 1'b0;
    timeout = 1'b0;
    case (state)
      IDLE: begin
        req = access;
        complete = access & dmem_ack;
        stall = ~(access & ~dmem_ack);
        next = !access ? IDLE : !dmem_ack ? WAIT : ext_stall_n ? IDLE : HOLD;
      end
      WAIT: begin
        req = 1'b1;
        timeout = ~dmem_ack & tmr_done;
        complete = dmem_ack | timeout;
        stall = complete;
        next = !complete ? WAIT : ext_stall_n ? IDLE : HOLD;
      end
      HOLD: next = ext_stall_n ? IDLE : HOLD;
      default: next = IDLE;
    endcase
  end
  // a watchdog abort returns zero data just like a store
  assign done_data = (is_load && !timeout) ? dmem_rdata : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      hold_reg <= '0;
      hold_to <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      state <= next;
      if (complete && !ext_stall_n) begin
        hold_reg <= done_data;
        hold_to <= timeout;
      end
      if (timeout) mem_err <= 1'b1;
    end
  assign dmem_req = req & ~rst;
  assign stall_n = stall | rst;
  assign dmem_we = mem_MemWrite;
  assign dmem_addr = mem_ALU_res;
  assign dmem_wdata = mem_wdata;
  assign out_data_mem = state == HOLD ? hold_reg : complete ? done_data : '0;
  // an aborted access must not write back, including while it waits in HOLD
  assign out_WriteReg = mem_WriteReg & ~timeout & ~(state == HOLD && hold_to);
  assign out_data_mux = mem_data_mux;
  assign out_rd = mem_rd;
  assign out_ALU_res = mem_ALU_res;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
  logic clk = 1'b0, rst = 1'b1, ext_stall_n = 1'b1;
  logic mem_MemRead = 1'b0, mem_MemWrite = 1'b0, mem_WriteReg = 1'b0, mem_data_mux = 1'b0;
  logic [3:0] mem_rd = '0;
  logic [15:0] mem_ALU_res = '0, mem_wdata = '0, dmem_rdata = '0;
  logic dmem_ack = 1'b0;
  logic dmem_req, dmem_we, out_WriteReg, out_data_mux, stall_n, mem_err;
  logic [15:0] dmem_addr, dmem_wdata, out_ALU_res, out_data_mem;
  logic [3:0] out_rd;
  int checks = 0, errors = 0;
  mem_access_stage dut (
    .clk(clk), .rst(rst), .ext_stall_n(ext_stall_n),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_WriteReg(mem_WriteReg), .mem_data_mux(mem_data_mux),
    .mem_rd(mem_rd), .mem_ALU_res(mem_ALU_res), .mem_wdata(mem_wdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .out_WriteReg(out_WriteReg), .out_data_mux(out_data_mux), .out_rd(out_rd),
    .out_ALU_res(out_ALU_res), .out_data_mem(out_data_mem),
    .stall_n(stall_n), .mem_err(mem_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    mem_MemRead = 1'b1;
    #1;
    chk("rst_req", 16'(dmem_req), 16'h0);
    chk("rst_stall_n", 16'(stall_n), 16'h1);
    chk("rst_mem_err", 16'(mem_err), 16'h0);
    tick();
    tick();
    rst = 1'b0;
    mem_MemRead = 1'b0;
    #1;
    chk("idle_req", 16'(dmem_req), 16'h0);
    // 1: zero-wait load
    tick();
    mem_MemRead = 1'b1; mem_ALU_res = 16'h0040; dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
    mem_WriteReg = 1'b1; mem_data_mux = 1'b1; mem_rd = 4'h5;
    #1;
    chk("t1_stall_n", 16'(stall_n), 16'h1);
    chk("t1_data", out_data_mem, 16'hBEEF);
    chk("t1_req", 16'(dmem_req), 16'h1);
    chk("t1_addr", dmem_addr, 16'h0040);
    chk("t1_we", 16'(dmem_we), 16'h0);
    chk("t1_rd", 16'(out_rd), 16'h5);
    chk("t1_wreg", 16'(out_WriteReg), 16'h1);
    tick();
    mem_MemRead = 1'b0; dmem_ack = 1'b0;
    #1;
    chk("t1_req_drop", 16'(dmem_req), 16'h0);
    chk("t1_data_drop", out_data_mem, 16'h0);
    // 2: load acked after 3 stall cycles
    tick();
    mem_MemRead = 1'b1; mem_ALU_res = 16'h0080; dmem_rdata = 16'hCAFE;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_stall_n", 16'(stall_n), 16'h0);
      chk("t2_req", 16'(dmem_req), 16'h1);
      chk("t2_addr", dmem_addr, 16'h0080);
      chk("t2_data", out_data_mem, 16'h0);
      tick();
    end
    dmem_ack = 1'b1;
    #1;
    chk("t2_ack_stall_n", 16'(stall_n), 16'h1);
    chk("t2_ack_req", 16'(dmem_req), 16'h1);
    chk("t2_ack_data", out_data_mem, 16'hCAFE);
    tick();
    mem_MemRead = 1'b0; dmem_ack = 1'b0;
    #1;
    chk("t2_after_req", 16'(dmem_req), 16'h0);
    chk("t2_after_data", out_data_mem, 16'h0);
    // 3: ack while another stage freezes the pipeline
    tick();
    mem_MemRead = 1'b1; dmem_ack = 1'b1; dmem_rdata = 16'h1357; ext_stall_n = 1'b0;
    #1;
    chk("t3_issue_data", out_data_mem, 16'h1357);
    chk("t3_issue_stall_n", 16'(stall_n), 16'h1);
    tick();
    dmem_ack = 1'b1; dmem_rdata = 16'hFFFF;
    #1;
    chk("t3_hold1_req", 16'(dmem_req), 16'h0);
    chk("t3_hold1_data", out_data_mem, 16'h1357);
    chk("t3_hold1_stall_n", 16'(stall_n), 16'h1);
    tick();
    dmem_ack = 1'b0; ext_stall_n = 1'b1;
    #1;
    chk("t3_hold2_req", 16'(dmem_req), 16'h0);
    chk("t3_hold2_data", out_data_mem, 16'h1357);
    tick();
    mem_MemRead = 1'b0;
    #1;
    chk("t3_idle_data", out_data_mem, 16'h0);
    chk("t3_idle_req", 16'(dmem_req), 16'h0);
    // 4: store with one wait cycle
    tick();
    mem_MemWrite = 1'b1; mem_ALU_res = 16'h00FF; mem_wdata = 16'h1234; dmem_rdata = 16'hAAAA;
    mem_WriteReg = 1'b0; mem_data_mux = 1'b0;
    #1;
    chk("t4_we", 16'(dmem_we), 16'h1);
    chk("t4_wdata", dmem_wdata, 16'h1234);
    chk("t4_addr", dmem_addr, 16'h00FF);
    chk("t4_stall_n", 16'(stall_n), 16'h0);
    tick();
    dmem_ack = 1'b1;
    #1;
    chk("t4_ack_stall_n", 16'(stall_n), 16'h1);
    chk("t4_ack_data", out_data_mem, 16'h0);
    chk("t4_ack_we", 16'(dmem_we), 16'h1);
    tick();
    mem_MemWrite = 1'b0; dmem_ack = 1'b0;
    // 5: memory never answers; watchdog aborts after 64 stalled cycles
    tick();
    mem_MemRead = 1'b1; mem_WriteReg = 1'b1; mem_ALU_res = 16'h0100; dmem_rdata = 16'h5555;
    for (int i = 0; i < 64; i++) begin
      #1;
      chk("t5_stall_n", 16'(stall_n), 16'h0);
      tick();
    end
    #1;
    chk("t5_to_stall_n", 16'(stall_n), 16'h1);
    chk("t5_to_wreg", 16'(out_WriteReg), 16'h0);
    chk("t5_to_data", out_data_mem, 16'h0);
    tick();
    mem_MemRead = 1'b0;
    #1;
    chk("t5_err", 16'(mem_err), 16'h1);
    tick();
    mem_MemRead = 1'b1; dmem_ack = 1'b1; dmem_rdata = 16'h2468;
    #1;
    chk("t5_next_data", out_data_mem, 16'h2468);
    chk("t5_next_wreg", 16'(out_WriteReg), 16'h1);
    chk("t5_err_sticky", 16'(mem_err), 16'h1);
    tick();
    mem_MemRead = 1'b0; dmem_ack = 1'b0;
    #1;
    chk("t5_err_sticky2", 16'(mem_err), 16'h1);
    // 6: reset mid-access, then a stray late ack
    tick();
    mem_MemRead = 1'b1;
    #1;
    chk("t6_stall_n", 16'(stall_n), 16'h0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_req", 16'(dmem_req), 16'h0);
    chk("t6_rst_stall_n", 16'(stall_n), 16'h1);
    chk("t6_rst_err", 16'(mem_err), 16'h0);
    tick();
    rst = 1'b0; mem_MemRead = 1'b0; dmem_ack = 1'b1; dmem_rdata = 16'h7777;
    #1;
    chk("t6_late_req", 16'(dmem_req), 16'h0);
    chk("t6_late_stall_n", 16'(stall_n), 16'h1);
    chk("t6_late_data", out_data_mem, 16'h0);
    chk("t6_late_err", 16'(mem_err), 16'h0);
    tick();
    dmem_ack = 1'b0;
    #1;
    chk("t6_idle_data", out_data_mem, 16'h0);
    chk("t6_idle_stall_n", 16'(stall_n), 16'h1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
